seq_calculator: RTL and testbench
=================================

SEQ_CALCULATOR -- requirements
Module: seq_calculator

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits (2..16).
REQ-002 SHALL have parameter DIGITS, default 4, seven-segment digit count (2..8).
REQ-003 SHALL have parameter REFRESH_DIV, default 50000, clk cycles each digit stays lit.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-007 SHALL have ports op1, op2  input  WIDTH  operands.
REQ-008 SHALL have port operation  input  2  0 add, 1 sub, 2 mul, 3 div.
REQ-009 SHALL have port sign  input  1  1 = operands and result two's complement.
REQ-010 SHALL have port busy  output  1  high from the cycle after start acceptance until done.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port result  output  2*WIDTH  last binary result, held until next done.
REQ-013 SHALL have port err  output  1  divide-by-zero flag, held until next done.
REQ-014 SHALL have port segBits  output  7  segments a..g, active-low.
REQ-015 SHALL have port trigger  output  DIGITS  one-hot active-low digit enable; bit 0 is the rightmost digit.

Function
REQ-016 SHALL use states IDLE -> CALC -> CONV -> IDLE.
REQ-017 In IDLE, start=1 SHALL capture op1, op2, operation and sign, then enter CALC.
REQ-018 CALC SHALL take 1 cycle for add/sub and WIDTH cycles for mul (shift-add) and div (restoring).
REQ-019 CONV SHALL convert |result| to BCD via double-dabble in exactly 2*WIDTH cycles.
REQ-020 done SHALL pulse on the CONV->IDLE edge; result, err and display registers SHALL update on that same edge.
REQ-021 start while busy SHALL be ignored with no queuing.
REQ-022 Signed mode SHALL sign-extend operands to 2*WIDTH; mul/div SHALL operate on magnitudes and re-apply the sign.
REQ-023 Division SHALL truncate toward zero and discard the remainder.
REQ-024 Divide by zero SHALL give result=0, err=1, and display "E" on digit 0 with all other digits blank.
REQ-025 Display: leading zeros blanked; digit 0 always shown; negative result puts '-' immediately left of the most-significant nonzero digit.
REQ-026 If the magnitude plus sign needs more than DIGITS positions, the display SHALL show '-' on every digit while result stays correct.
REQ-027 The scan counter SHALL advance trigger by one digit every REFRESH_DIV cycles, wrapping DIGITS-1 -> 0, independent of FSM state.

Reset
REQ-028 rst_n=0 SHALL immediately force: state IDLE, busy=0, done=0, result=0, err=0, trigger=~1, scan counter 0, display "0" on digit 0 with other digits blank.
REQ-029 Reset during CALC/CONV SHALL abort with no done pulse; the next start after release SHALL operate normally.

Configuration
REQ-030 With macro CALC_DIV_EN defined, the divider SHALL be built per REQ-018/023/024.
REQ-031 Without CALC_DIV_EN, operation=3 SHALL skip CALC/CONV, pulse done 1 cycle after acceptance with result=0 and err=1, and display "E"; no divider logic SHALL be synthesised.

Structure
REQ-032 Package calc_pkg SHALL hold the op_e enum, the state_e enum and the segment constants (digits 0-9, blank, minus, E).
REQ-033 The double-dabble converter SHALL be sub-module bin2bcd_seq with start/done handshake, parametrised by input width and DIGITS.

Verification (WIDTH=4, DIGITS=4, REFRESH_DIV=4)
REQ-034 Unsigned 7+9 -> result=8'h10, done 9 cycles after acceptance, display "  16".
REQ-035 Signed 4'hD (-3) * 5 -> result=8'hF1, done 12 cycles after acceptance, display " -15".
REQ-036 Unsigned 15*15 -> result=8'hE1, display " 225"; signed 4'h8 / 4'h1 -> result=8'hF8, display "  -8".
REQ-037 9/0 -> err=1, result=0, display "   E"; repeat without CALC_DIV_EN -> done 1 cycle after acceptance, err=1.
REQ-038 start pulsed during busy -> no extra done; rst_n low mid-CALC -> busy=0 immediately, no done.
REQ-039 Idle after reset -> trigger sequence 1110, 1101, 1011, 0111, 1110, each held exactly 4 cycles.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : calc_pkg
// Brief   : Shared types, segment encodings and helpers for seq_calculator.
// Revision: 1.0
// ============================================================================
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CONV = 2'd2
  } state_e;

  // Active-low segments; bit 0 is segment a, bit 6 is segment g.
  localparam logic [6:0] c_seg_0     = 7'h40;
  localparam logic [6:0] c_seg_1     = 7'h79;
  localparam logic [6:0] c_seg_2     = 7'h24;
  localparam logic [6:0] c_seg_3     = 7'h30;
  localparam logic [6:0] c_seg_4     = 7'h19;
  localparam logic [6:0] c_seg_5     = 7'h12;
  localparam logic [6:0] c_seg_6     = 7'h02;
  localparam logic [6:0] c_seg_7     = 7'h78;
  localparam logic [6:0] c_seg_8     = 7'h00;
  localparam logic [6:0] c_seg_9     = 7'h10;
  localparam logic [6:0] c_seg_blank = 7'h7F;
  localparam logic [6:0] c_seg_minus = 7'h3F;
  localparam logic [6:0] c_seg_e     = 7'h06;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = c_seg_0;
      4'd1:    s = c_seg_1;
      4'd2:    s = c_seg_2;
      4'd3:    s = c_seg_3;
      4'd4:    s = c_seg_4;
      4'd5:    s = c_seg_5;
      4'd6:    s = c_seg_6;
      4'd7:    s = c_seg_7;
      4'd8:    s = c_seg_8;
      4'd9:    s = c_seg_9;
      default: s = c_seg_blank;
    endcase
    return s;
  endfunction

  // Decimal digits needed to hold any unsigned value of the given bit width.
  function automatic int dec_digits(input int bits);
    logic [63:0] v;
    int          n;
    v = (64'd1 << bits) - 64'd1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 64'd0) begin
        v = v / 64'd10;
        n = n + 1;
      end
    end
    return (n < 1) ? 1 : n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module  : bin2bcd_seq
// Brief   : Sequential double-dabble converter, one bit per cycle, IN_W cycles
//           from start to the done pulse. ovf flags digits beyond DIGITS.
// Revision: 1.0
// ============================================================================
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int c_need = dec_digits(IN_W);
  localparam int c_bd   = (c_need > DIGITS) ? c_need : DIGITS;
  localparam int c_cw   = $clog2(IN_W + 1);

  logic [4*c_bd-1:0] r_bcd;
  logic [4*c_bd-1:0] w_adj;
  logic [IN_W-1:0]   r_sh;
  logic [c_cw-1:0]   r_cnt;
  logic              r_busy;
  logic              r_done;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < c_bd; i++) begin
      if (r_bcd[4*i +: 4] > 4'd4) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // The load cycle already shifts in the MSB (all BCD digits are zero then),
  // so the remaining IN_W-1 bits follow on consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd  <= '0;
      r_sh   <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_bcd  <= {{(4*c_bd-1){1'b0}}, bin[IN_W-1]};
        r_sh   <= bin << 1;
        r_cnt  <= c_cw'(IN_W - 1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_bcd <= {w_adj[4*c_bd-2:0], r_sh[IN_W-1]};
        r_sh  <= r_sh << 1;
        r_cnt <= r_cnt - c_cw'(1);
        if (r_cnt == c_cw'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done = r_done;
  assign bcd  = r_bcd[4*DIGITS-1:0];

  generate
    if (c_bd > DIGITS) begin : g_ovf
      assign ovf = |r_bcd[4*c_bd-1:4*DIGITS];
    end else begin : g_no_ovf
      assign ovf = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/seq_calculator.sv
`default_nettype none
// ============================================================================
// Module  : seq_calculator
// Brief   : Sequential add/sub/mul/div calculator with a multiplexed
//           seven-segment readout. Divider is built only with CALC_DIV_EN.
// Revision: 1.0
// ============================================================================
module seq_calculator
  import calc_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     op1,
  input  logic [WIDTH-1:0]     op2,
  input  logic [1:0]           operation,
  input  logic                 sign,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 err,
  output logic [6:0]           segBits,
  output logic [DIGITS-1:0]    trigger
);

  localparam int c_rw = 2 * WIDTH;
  localparam int c_cw = $clog2(WIDTH + 1);
  localparam int c_dw = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int c_iw = $clog2(DIGITS);

  state_e              r_state;
  op_e                 r_op;
  logic                r_sign;
  logic                r_neg;
  logic                r_res_neg;
  logic                r_err_pend;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_mplier;
  logic [c_rw-1:0]     r_acc;
  logic [c_rw-1:0]     r_mcand;
  logic [c_rw-1:0]     r_res;
  logic [c_cw-1:0]     r_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [c_rw-1:0]     r_result;
  logic [6:0]          r_disp [DIGITS];
  logic [c_dw-1:0]     r_div;
  logic [c_iw-1:0]     r_idx;
  logic [DIGITS-1:0]   r_trig;

  logic                w_n1;
  logic                w_n2;
  logic [WIDTH-1:0]    w_mag1;
  logic [WIDTH-1:0]    w_mag2;
  logic [c_rw-1:0]     w_ext_a;
  logic [c_rw-1:0]     w_ext_b;
  logic [c_rw-1:0]     w_addsub;
  logic [c_rw-1:0]     w_acc_next;
  logic [c_rw-1:0]     w_prod;
  logic [c_rw-1:0]     w_calc_res;
  logic [c_rw-1:0]     w_mag;
  logic                w_last;
  logic                w_calc_err;
  logic                w_skip;
  logic                w_res_neg;
  logic                w_conv_start;
  logic [4*DIGITS-1:0] w_bcd;
  logic                w_bcd_done;
  logic                w_bcd_ovf;
  logic [c_iw-1:0]     w_msd;
  logic                w_full;
  logic [6:0]          w_disp [DIGITS];

  // Operand magnitudes feed mul/div; the result sign is re-applied at the end.
  assign w_n1   = sign & op1[WIDTH-1];
  assign w_n2   = sign & op2[WIDTH-1];
  assign w_mag1 = w_n1 ? -op1 : op1;
  assign w_mag2 = w_n2 ? -op2 : op2;

  assign w_ext_a    = r_sign ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
  assign w_ext_b    = r_sign ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
  assign w_addsub   = (r_op == OP_SUB) ? (w_ext_a - w_ext_b) : (w_ext_a + w_ext_b);
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_prod     = r_neg ? -w_acc_next : w_acc_next;

`ifdef CALC_DIV_EN
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic             r_dz;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic [c_rw-1:0]  w_quot;

  assign w_rem_sh   = {r_rem, r_q[WIDTH-1]};
  assign w_trial    = w_rem_sh - {1'b0, r_dvs};
  assign w_q_next   = {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
  assign w_rem_next = w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quot     = r_neg ? -{{WIDTH{1'b0}}, w_q_next} : {{WIDTH{1'b0}}, w_q_next};
  assign w_skip     = 1'b0;
`else
  assign w_skip     = (r_op == OP_DIV);
`endif

  always_comb begin
    w_last     = 1'b1;
    w_calc_res = w_addsub;
    w_calc_err = 1'b0;
    case (r_op)
      OP_MUL: begin
        w_last     = (r_cnt == c_cw'(WIDTH - 1));
        w_calc_res = w_prod;
      end
      OP_DIV: begin
`ifdef CALC_DIV_EN
        w_last     = (r_cnt == c_cw'(WIDTH - 1));
        w_calc_res = r_dz ? '0 : w_quot;
        w_calc_err = r_dz;
`else
        w_calc_res = '0;
        w_calc_err = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  assign w_res_neg    = r_sign & w_calc_res[c_rw-1];
  assign w_mag        = w_res_neg ? -w_calc_res : w_calc_res;
  assign w_conv_start = (r_state == CALC) & w_last & ~w_skip;

  bin2bcd_seq #(
    .IN_W   (c_rw),
    .DIGITS (DIGITS)
  ) u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_conv_start),
    .bin   (w_mag),
    .done  (w_bcd_done),
    .bcd   (w_bcd),
    .ovf   (w_bcd_ovf)
  );

  always_comb begin
    w_msd = '0;
    for (int i = 1; i < DIGITS; i++) begin
      if (w_bcd[4*i +: 4] != 4'd0) w_msd = c_iw'(i);
    end
    // The sign needs its own position left of the most significant digit.
    w_full = w_bcd_ovf | (r_res_neg & (int'(w_msd) == DIGITS - 1));
    for (int i = 0; i < DIGITS; i++) begin
      w_disp[i] = c_seg_blank;
      if (r_err_pend) begin
        if (i == 0) w_disp[i] = c_seg_e;
      end else if (w_full) begin
        w_disp[i] = c_seg_minus;
      end else if (i <= int'(w_msd)) begin
        w_disp[i] = seg_digit(w_bcd[4*i +: 4]);
      end else if (r_res_neg && (i == int'(w_msd) + 1)) begin
        w_disp[i] = c_seg_minus;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_op       <= OP_ADD;
      r_sign     <= 1'b0;
      r_neg      <= 1'b0;
      r_res_neg  <= 1'b0;
      r_err_pend <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_res      <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_result   <= '0;
      for (int i = 0; i < DIGITS; i++) r_disp[i] <= (i == 0) ? c_seg_0 : c_seg_blank;
`ifdef CALC_DIV_EN
      r_q   <= '0;
      r_dvs <= '0;
      r_rem <= '0;
      r_dz  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op     <= op_e'(operation);
            r_sign   <= sign;
            r_a      <= op1;
            r_b      <= op2;
            r_neg    <= w_n1 ^ w_n2;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, w_mag1};
            r_mplier <= w_mag2;
`ifdef CALC_DIV_EN
            r_q      <= w_mag1;
            r_dvs    <= w_mag2;
            r_rem    <= '0;
            r_dz     <= (op2 == '0);
`endif
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= CALC;
          end
        end
        CALC: begin
          r_cnt <= r_cnt + c_cw'(1);
          if (r_op == OP_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
          end
`ifdef CALC_DIV_EN
          if (r_op == OP_DIV) begin
            r_q   <= w_q_next;
            r_rem <= w_rem_next;
          end
`endif
          if (w_last) begin
            r_res      <= w_calc_res;
            r_err_pend <= w_calc_err;
            r_res_neg  <= w_res_neg;
            if (w_skip) begin
              r_state  <= IDLE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_result <= '0;
              r_err    <= 1'b1;
              for (int i = 0; i < DIGITS; i++) r_disp[i] <= (i == 0) ? c_seg_e : c_seg_blank;
            end else begin
              r_state <= CONV;
            end
          end
        end
        CONV: begin
          if (w_bcd_done) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= r_res;
            r_err    <= r_err_pend;
            for (int i = 0; i < DIGITS; i++) r_disp[i] <= w_disp[i];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Digit scan runs freely regardless of the calculator state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_idx  <= '0;
      r_trig <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else if (r_div == c_dw'(REFRESH_DIV - 1)) begin
      r_div  <= '0;
      r_trig <= {r_trig[DIGITS-2:0], r_trig[DIGITS-1]};
      r_idx  <= (r_idx == c_iw'(DIGITS - 1)) ? '0 : r_idx + c_iw'(1);
    end else begin
      r_div <= r_div + c_dw'(1);
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign result  = r_result;
  assign err     = r_err;
  assign trigger = r_trig;
  assign segBits = r_disp[r_idx];

endmodule
`default_nettype wire

// File: tb/tb_seq_calculator.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_calculator
// Brief   : Directed self-checking bench for seq_calculator (W=4, D=4, R=4).
// Revision: 1.0
// ============================================================================
module tb_seq_calculator;

  localparam int W = 4;
  localparam int D = 4;
  localparam int R = 4;
`ifdef CALC_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op1 = '0;
  logic [W-1:0] op2 = '0;
  logic [1:0]   operation = '0;
  logic         sign = 1'b0;
  logic         busy;
  logic         done;
  logic [2*W-1:0] result;
  logic         err;
  logic [6:0]   segBits;
  logic [D-1:0] trigger;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_calculator #(
    .WIDTH       (W),
    .DIGITS      (D),
    .REFRESH_DIV (R)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op1       (op1),
    .op2       (op2),
    .operation (operation),
    .sign      (sign),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .err       (err),
    .segBits   (segBits),
    .trigger   (trigger)
  );

  typedef struct {
    logic [1:0]  op;
    logic        sgn;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [7:0]  res;
    logic        er;
    int          lat;
    logic [31:0] disp;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic [1:0] op, input logic s, input logic [3:0] a,
                              input logic [3:0] b, input logic [7:0] r, input logic e,
                              input int l, input logic [31:0] d);
    vec_t v;
    v.op = op; v.sgn = s; v.a = a; v.b = b; v.res = r; v.er = e; v.lat = l; v.disp = d;
    return v;
  endfunction

  // Without the divider every division reports an error one cycle after acceptance.
  function automatic vec_t mkdiv(input logic s, input logic [3:0] a, input logic [3:0] b,
                                 input logic [7:0] r, input logic e, input logic [31:0] d);
    return DIV_EN ? mk(2'd3, s, a, b, r, e, 12, d) : mk(2'd3, s, a, b, 8'h00, 1'b1, 1, "   E");
  endfunction

  function automatic logic [6:0] seg_of(input logic [7:0] ch);
    logic [6:0] s;
    case (ch)
      "0": s = 7'h40;  "1": s = 7'h79;  "2": s = 7'h24;  "3": s = 7'h30;
      "4": s = 7'h19;  "5": s = 7'h12;  "6": s = 7'h02;  "7": s = 7'h78;
      "8": s = 7'h00;  "9": s = 7'h10;  "-": s = 7'h3F;  "E": s = 7'h06;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  function automatic logic [27:0] exp_segs(input logic [31:0] s);
    logic [27:0] r;
    for (int i = 0; i < D; i++) r[7*i +: 7] = seg_of(s[8*i +: 8]);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full scan: capture the segments shown while each digit is enabled.
  task automatic read_disp(output logic [27:0] segs);
    segs = 'x;
    for (int c = 0; c < D * R; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < D; i++) if (trigger[i] == 1'b0) segs[7*i +: 7] = segBits;
    end
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int          lat;
    logic [27:0] segs;
    @(negedge clk);
    operation = v.op; sign = v.sgn; op1 = v.a; op2 = v.b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check($sformatf("v%0d_busy", k), {31'd0, busy}, 32'd1);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    check($sformatf("v%0d_latency", k), lat, v.lat);
    check($sformatf("v%0d_result", k), {24'd0, result}, {24'd0, v.res});
    check($sformatf("v%0d_err", k), {31'd0, err}, {31'd0, v.er});
    read_disp(segs);
    check($sformatf("v%0d_display", k), {4'd0, segs}, {4'd0, exp_segs(v.disp)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0] segs;
    int          ndone;

    vecs[0]  = mk(2'd0, 1'b0, 4'h7, 4'h9, 8'h10, 1'b0, 9,  "  16");
    vecs[1]  = mk(2'd2, 1'b1, 4'hD, 4'h5, 8'hF1, 1'b0, 12, " -15");
    vecs[2]  = mk(2'd2, 1'b0, 4'hF, 4'hF, 8'hE1, 1'b0, 12, " 225");
    vecs[3]  = mkdiv(1'b1, 4'h8, 4'h1, 8'hF8, 1'b0, "  -8");
    vecs[4]  = mkdiv(1'b0, 4'h9, 4'h0, 8'h00, 1'b1, "   E");
    vecs[5]  = mk(2'd1, 1'b1, 4'h3, 4'h5, 8'hFE, 1'b0, 9,  "  -2");
    vecs[6]  = mk(2'd1, 1'b0, 4'h3, 4'h5, 8'hFE, 1'b0, 9,  " 254");
    vecs[7]  = mk(2'd2, 1'b1, 4'h8, 4'h8, 8'h40, 1'b0, 12, "  64");
    vecs[8]  = mk(2'd2, 1'b1, 4'h7, 4'h8, 8'hC8, 1'b0, 12, " -56");
    vecs[9]  = mkdiv(1'b0, 4'hF, 4'h4, 8'h03, 1'b0, "   3");
    vecs[10] = mkdiv(1'b1, 4'h7, 4'hE, 8'hFD, 1'b0, "  -3");
    vecs[11] = mk(2'd0, 1'b1, 4'h0, 4'h0, 8'h00, 1'b0, 9,  "   0");
    vecs[12] = mk(2'd0, 1'b1, 4'h8, 4'h8, 8'hF0, 1'b0, 9,  " -16");
    vecs[13] = mk(2'd2, 1'b0, 4'h0, 4'h9, 8'h00, 1'b0, 12, "   0");

    // Reset state, then the free-running digit scan after release.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_trigger", {28'd0, trigger}, 32'he);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 20; k++) begin
      logic [3:0] t;
      if (k > 0) begin
        @(posedge clk); #1;
      end
      t = ~(4'b0001 << ((k / 4) % 4));
      check($sformatf("scan_%0d", k), {28'd0, trigger}, {28'd0, t});
    end
    read_disp(segs);
    check("rst_display", {4'd0, segs}, {4'd0, exp_segs("   0")});

    for (int k = 0; k < 14; k++) run_vec(vecs[k], k);

    // Start requests while busy must be dropped, in CALC and in CONV.
    @(negedge clk);
    operation = 2'd2; sign = 1'b0; op1 = 4'h3; op2 = 4'h3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = (n == 2) || (n == 7);
      operation = 2'd0; op1 = 4'h1; op2 = 4'h1;
      @(posedge clk); #1;
      start = 1'b0;
      if (done) ndone++;
    end
    check("busy_ignore_dones", ndone, 1);
    check("busy_ignore_result", {24'd0, result}, 32'h09);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    operation = 2'd2; sign = 1'b0; op1 = 4'h5; op2 = 4'h5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", {24'd0, result}, 32'd0);
    check("abort_trigger", {28'd0, trigger}, 32'he);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_vec(vecs[1], 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
